// File: rtl/video_pattern_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pattern_pkg                                                    |
// | Colour constants and colour-state encoding for the banded pattern.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package video_pattern_pkg;

  typedef enum logic [1:0] {
    COL_C1 = 2'd0,
    COL_C2 = 2'd1,
    COL_C3 = 2'd2,
    COL_C4 = 2'd3
  } colour_e;

  localparam logic [23:0] c_wisteria     = {8'd142, 8'd68,  8'd173};
  localparam logic [23:0] c_midnightblue = {8'd44,  8'd62,  8'd80};
  localparam logic [23:0] c_greensea     = {8'd22,  8'd160, 8'd133};
  localparam logic [23:0] c_belize       = {8'd41,  8'd128, 8'd185};

  localparam int c_def_tile_pixels    = 80;
  localparam int c_def_tiles_per_band = 500;

  function automatic logic [23:0] colour_rgb(input colour_e col);
    logic [23:0] rgb;
    case (col)
      COL_C1:  rgb = c_wisteria;
      COL_C2:  rgb = c_midnightblue;
      COL_C3:  rgb = c_greensea;
      default: rgb = c_belize;
    endcase
    return rgb;
  endfunction

  // Partner colour within the current pair.
  function automatic colour_e colour_toggle(input colour_e col);
    colour_e nxt;
    case (col)
      COL_C1:  nxt = COL_C2;
      COL_C2:  nxt = COL_C1;
      COL_C3:  nxt = COL_C4;
      default: nxt = COL_C3;
    endcase
    return nxt;
  endfunction

  function automatic colour_e colour_band_next(input colour_e col);
    return ((col == COL_C1) || (col == COL_C2)) ? COL_C3 : COL_C1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pattern_checker_if                                             |
// | Pixel stream, control and result signals of the pattern checker.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface video_pattern_checker_if #(
  parameter int ERR_W = 16
) ();

  logic             start;
  logic             video_ready;
  logic [23:0]      video_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] error_count;
  logic [31:0]      first_err_index;
  logic [23:0]      first_err_data;

  modport master (
    output start, video_ready, video_in,
    input  busy, done, pass, error_count, first_err_index, first_err_data
  );

  modport slave (
    input  start, video_ready, video_in,
    output busy, done, pass, error_count, first_err_index, first_err_data
  );

endinterface
`default_nettype wire

// File: rtl/pattern_expect_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_expect_seq                                                   |
// | Tile/band counters and colour state; presents the expected pixel.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pattern_expect_seq
  import video_pattern_pkg::*;
#(
  parameter int TILE_PIXELS    = c_def_tile_pixels,
  parameter int TILES_PER_BAND = c_def_tiles_per_band
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        step,
  input  wire logic        restart,
  output logic [23:0]      expected,
  output colour_e          colour
);

  localparam int PW = (TILE_PIXELS > 1) ? $clog2(TILE_PIXELS) : 1;
  localparam int TW = (TILES_PER_BAND > 1) ? $clog2(TILES_PER_BAND) : 1;
  localparam logic [PW-1:0] c_pix_last  = PW'(TILE_PIXELS - 1);
  localparam logic [TW-1:0] c_tile_last = TW'(TILES_PER_BAND - 1);

  logic [PW-1:0] r_pix_cnt;
  logic [TW-1:0] r_tile_cnt;
  colour_e       r_colour;

  // restart wins over step so a new run always begins on C1 at pixel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_tile_cnt <= '0;
      r_colour   <= COL_C1;
    end else if (restart) begin
      r_pix_cnt  <= '0;
      r_tile_cnt <= '0;
      r_colour   <= COL_C1;
    end else if (step) begin
      if (r_pix_cnt == c_pix_last) begin
        r_pix_cnt <= '0;
        if (r_tile_cnt == c_tile_last) begin
          r_tile_cnt <= '0;
          r_colour   <= colour_band_next(r_colour);
        end else begin
          r_tile_cnt <= r_tile_cnt + TW'(1);
          r_colour   <= colour_toggle(r_colour);
        end
      end else begin
        r_pix_cnt <= r_pix_cnt + PW'(1);
      end
    end
  end

  assign colour   = r_colour;
  assign expected = colour_rgb(r_colour);

endmodule
`default_nettype wire

// File: rtl/video_pattern_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pattern_checker                                                |
// | Compares a pixel stream against the banded four-colour pattern.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_pattern_checker
  import video_pattern_pkg::*;
#(
  parameter int TILE_PIXELS    = c_def_tile_pixels,
  parameter int TILES_PER_BAND = c_def_tiles_per_band,
  parameter int CHECK_PIXELS   = 160000,
  parameter int ERR_W          = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  video_pattern_checker_if.slave vif
);

  localparam logic [1:0]  c_st_idle  = 2'd0;
  localparam logic [1:0]  c_st_check = 2'd1;
  localparam logic [1:0]  c_st_done  = 2'd2;
  localparam logic [31:0] c_last_idx = 32'(CHECK_PIXELS - 1);

  logic [1:0]       r_state;
  logic [31:0]      r_index;
  logic [ERR_W-1:0] r_err_count;
  logic [31:0]      r_first_idx;
  logic [23:0]      r_first_data;
  logic             r_done;
  logic             r_pass;

  logic             w_in_check;
  logic             w_restart;
  logic             w_step;
  logic             w_mismatch;
  logic             w_no_err_yet;
  logic [23:0]      w_expected;
  colour_e          w_colour;

  assign w_in_check   = (r_state == c_st_check);
  assign w_restart    = vif.start && !w_in_check;
  assign w_step       = w_in_check && vif.video_ready;
  assign w_mismatch   = w_step && (vif.video_in != w_expected);
  assign w_no_err_yet = (r_err_count == '0);

  pattern_expect_seq #(
    .TILE_PIXELS    (TILE_PIXELS),
    .TILES_PER_BAND (TILES_PER_BAND)
  ) u_expect (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (w_step),
    .restart  (w_restart),
    .expected (w_expected),
    .colour   (w_colour)
  );

  // A strobe coinciding with a restart is dropped: w_step is low outside CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_index      <= '0;
      r_err_count  <= '0;
      r_first_idx  <= '0;
      r_first_data <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (w_restart) begin
      r_state      <= c_st_check;
      r_index      <= '0;
      r_err_count  <= '0;
      r_first_idx  <= '0;
      r_first_data <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (w_step) begin
      r_index <= r_index + 32'd1;
      if (w_mismatch) begin
        if (!(&r_err_count)) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
        if (w_no_err_yet) begin
          r_first_idx  <= r_index;
          r_first_data <= vif.video_in;
        end
      end
      if (r_index == c_last_idx) begin
        r_state <= c_st_done;
        r_done  <= 1'b1;
        r_pass  <= !w_mismatch && w_no_err_yet;
      end
    end
  end

  assign vif.busy            = w_in_check;
  assign vif.done            = r_done;
  assign vif.pass            = r_pass;
  assign vif.error_count     = r_err_count;
  assign vif.first_err_index = r_first_idx;
  assign vif.first_err_data  = r_first_data;

endmodule
`default_nettype wire

// File: doc/video_pattern_checker.md
Name: video_pattern_checker

Overview:
- Sink-side counterpart to the banded four-colour video pattern generator.
- Consumes the 24-bit pixel stream on the same VideoReady strobe that advances the generator.
- Regenerates the expected tile/band colour sequence locally and compares it pixel by pixel against the stream.
- Reports pass/fail, a saturating error count and the first mismatch, for board bring-up and for the SIFT front-end's self-test path.

Parameters:
- TILE_PIXELS, 80: pixels per colour tile before toggling to the partner colour.
- TILES_PER_BAND, 500: tiles per band before switching colour pair.
- CHECK_PIXELS, 160000: pixels checked per run; must be ≥1. Default covers 4 bands.
- ERR_W, 16: ErrorCount width.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse; begins a check run.
- VideoReady  in  1  pixel strobe; VideoIn is valid and consumed in any cycle this is high.
- VideoIn  in  24  pixel {R,G,B}, 8 bits each.
- Busy  out  1  high while a run is in progress.
- Done  out  1  high once a run completes; held until next Start.
- Pass  out  1  valid when Done; high iff ErrorCount==0.
- ErrorCount  out  ERR_W  mismatching pixels, saturating at all-ones.
- FirstErrIndex  out  32  pixel index (0-based) of the first mismatch.
- FirstErrData  out  24  VideoIn value at the first mismatch.

Behaviour:
- Reset (async assert, sync release): state IDLE; Busy=0, Done=0, Pass=0, ErrorCount=0, FirstErrIndex=0, FirstErrData=0; expected colour state = C1; pixel/tile/index counters = 0.
- Colour constants:
  - C1 WISTERIA {142,68,173}
  - C2 MIDNIGHTBLUE {44,62,80}
  - C3 GREENSEA {22,160,133}
  - C4 BELIZE {41,128,185}
- Expected sequence:
  - The colour holds for TILE_PIXELS strobes.
  - At a tile end not on a band boundary: C1↔C2, C3↔C4.
  - On the last tile of a band (tile counter == TILES_PER_BAND-1): C1/C2→C3, C3/C4→C1; tile counter wraps to 0.
- FSM:
  - IDLE: Start → CHECK. On entry, clear ErrorCount, FirstErr*, counters and Done/Pass; expected = C1. VideoReady is ignored.
  - CHECK: Busy=1. Each VideoReady cycle:
    - compare VideoIn to expected;
    - advance pixel counter, tile counter, colour and index at that same edge;
    - mismatch → ErrorCount+1 (saturating); if first mismatch, latch FirstErrIndex=index and FirstErrData=VideoIn.
    - The edge sampling index CHECK_PIXELS-1 → DONE. Its own compare result is included.
  - DONE: Busy=0, Done=1, Pass=(ErrorCount==0). Start → CHECK, with the same clearing as the IDLE entry.
- Latency: zero added cycles. Counters and outputs reflect a sampled pixel immediately after the edge it was sampled on.
- Start during CHECK is ignored; the run continues.
- Start and VideoReady in the same cycle from IDLE/DONE: that pixel is not checked; the first checked pixel is the next strobe.
- VideoReady low: no state change. Arbitrary gaps between strobes are legal.
- ErrorCount saturation: at all-ones it holds. Pass stays 0.
- Reset mid-run: immediate abort to reset values; no partial result is retained.
- Alignment: generator and checker must leave reset (or start) before the first strobe. Misalignment is reported as errors, not resynchronised.

Decomposition:
- Shared package `video_pattern_pkg`:
  - the four colour constants;
  - colour-state encoding (C1..C4);
  - default TILE_PIXELS / TILES_PER_BAND.
- The generator is refactored to use the same package.
- One natural sub-module, `pattern_expect_seq`: holds the tile/band counters and colour state, outputs the expected pixel, advances on `step`, clears on `restart`. It is reusable by the generator.

Test Plan:
- Reset, Start, then 160000 correct strobes (generator-driven, VideoReady every cycle) → Done=1, Pass=1, ErrorCount=0 on the edge sampling the last pixel.
- Same as above with VideoReady 1-of-3 cycles → identical result; Busy high throughout; no check on idle cycles.
- Corrupt pixel index 80 (expect C2) with 0x000000 → ErrorCount=1, FirstErrIndex=80, FirstErrData=0x000000, Pass=0. Pixel index 39999→40000 boundary checks C1/C2→C3 at index 40000.
- TILE_PIXELS=2, TILES_PER_BAND=2, CHECK_PIXELS=8, constant 0xFFFFFF input → ErrorCount=8, FirstErrIndex=0. With ERR_W=2, saturates at 3.
- Start pulsed mid-run at pixel 100 → ignored. Start with VideoReady in DONE → next run excludes that pixel and results are cleared.
- Reset deasserted→asserted asynchronously mid-run (between edges) → all outputs zero immediately; a subsequent Start runs clean to Pass=1.
